// File: rtl/phase_tag_decoder.sv
// Unpacks phase_tag words into signed quarter-period delay and start period, queued in an FWFT FIFO.
// Optional feature macro: PHASE_TAG_DECODER_AVG_EN (windowed delay averaging over 2^AVG_LOG2 tags).
module phase_tag_decoder #(
  parameter int PHASE_COUNT_SIZE = 6,
  parameter int CLK_0_COUNT_SIZE = 6,
  parameter int FIFO_DEPTH       = 4,
  parameter int AVG_LOG2         = 2
) (
  input  logic                                       clk_0,
  input  logic                                       rst,
  input  logic [CLK_0_COUNT_SIZE+PHASE_COUNT_SIZE+3:0] phase_tag,
  input  logic                                       phase_tag_valid,
  output logic [PHASE_COUNT_SIZE+2:0]                out_delay,
  output logic [CLK_0_COUNT_SIZE-1:0]                out_period,
  output logic                                       out_period_valid,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       overflow,
  input  logic                                       clr_overflow
);

  localparam int TW = CLK_0_COUNT_SIZE + PHASE_COUNT_SIZE + 4;
  localparam int DW = PHASE_COUNT_SIZE + 3;
  localparam int PW = CLK_0_COUNT_SIZE;
  localparam int EW = DW + PW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } track_state_t;

  track_state_t state, state_next;

  logic [PW-1:0]               tag_start;
  logic [PHASE_COUNT_SIZE-1:0] tag_phase;
  logic [1:0]                  tag_start_phase;
  logic [1:0]                  tag_stop_phase;
  logic [DW-1:0]               delay_calc;
  logic [PW-1:0]               period_calc;
  logic                        period_valid_calc;
  logic [PW-1:0]               prev_start;

  logic          s1_valid;
  logic [DW-1:0] s1_delay;
  logic [PW-1:0] s1_period;
  logic          s1_period_valid;

  logic          push;
  logic [DW-1:0] push_delay;
  logic [EW-1:0] push_entry;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [EW-1:0] head;

  assign tag_start       = phase_tag[TW-1 -: PW];
  assign tag_phase       = phase_tag[PHASE_COUNT_SIZE+3:4];
  assign tag_start_phase = phase_tag[3:2];
  assign tag_stop_phase  = phase_tag[1:0];

  // Modular DW-bit arithmetic yields the two's-complement delay directly; range never overflows DW.
  assign delay_calc = {1'b0, tag_phase, 2'b00}
                    + {{(DW-2){1'b0}}, tag_stop_phase}
                    - {{(DW-2){1'b0}}, tag_start_phase};

  // Tracking state register
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Tracking next state and period computation
  always_comb begin
    state_next        = state;
    period_calc       = '0;
    period_valid_calc = 1'b0;
    case (state)
      IDLE: begin
        if (phase_tag_valid) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        period_calc       = tag_start - prev_start;
        period_valid_calc = 1'b1;
        state_next        = RUN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Previous start count holder
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      prev_start <= '0;
    end else if (phase_tag_valid) begin
      prev_start <= tag_start;
    end else begin
      prev_start <= prev_start;
    end
  end

  // Stage 1 result register
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_delay        <= '0;
      s1_period       <= '0;
      s1_period_valid <= 1'b0;
    end else begin
      s1_valid <= phase_tag_valid;
      if (phase_tag_valid) begin
        s1_delay        <= delay_calc;
        s1_period       <= period_calc;
        s1_period_valid <= period_valid_calc;
      end else begin
        s1_delay        <= s1_delay;
        s1_period       <= s1_period;
        s1_period_valid <= s1_period_valid;
      end
    end
  end

`ifdef PHASE_TAG_DECODER_AVG_EN
  localparam int AccW = DW + AVG_LOG2;
  localparam int WCW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] acc_sum;
  logic [WCW-1:0]         win_cnt;
  logic                   win_last;

  // Window sum and floor average of the closing window
  always_comb begin
    acc_sum    = acc + AccW'($signed(s1_delay));
    win_last   = (win_cnt == WCW'((1 << AVG_LOG2) - 1));
    push       = s1_valid && win_last;
    push_delay = DW'(acc_sum >>> AVG_LOG2);
  end

  // Accumulator and window counter
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (s1_valid) begin
      if (win_last) begin
        acc     <= '0;
        win_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        win_cnt <= win_cnt + WCW'(1);
      end
    end else begin
      acc     <= acc;
      win_cnt <= win_cnt;
    end
  end
`else
  assign push       = s1_valid;
  assign push_delay = s1_delay;
`endif

  assign push_entry = {push_delay, s1_period, s1_period_valid};

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = out_valid && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO occupancy update
  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage, pointers and registered valid flag
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      count     <= count_next;
      out_valid <= (count_next != '0);
    end
  end

  // Sticky overflow; a drop outranks a same-cycle clear
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  assign head             = mem[rd_ptr];
  assign out_delay        = head[EW-1 -: DW];
  assign out_period       = head[PW:1];
  assign out_period_valid = head[0];

endmodule

// File: tb/tb_phase_tag_decoder.sv
// Scoreboard bench for phase_tag_decoder: randomized and directed tags against a behavioural model.
module tb_phase_tag_decoder;

  localparam int DEPTH = 4;

  logic        clk_0 = 1'b0;
  logic        rst;
  logic [15:0] phase_tag;
  logic        phase_tag_valid;
  logic [8:0]  out_delay;
  logic [5:0]  out_period;
  logic        out_period_valid;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clr_overflow;

  int checks = 0;
  int errors = 0;

  phase_tag_decoder dut (
    .clk_0            (clk_0),
    .rst              (rst),
    .phase_tag        (phase_tag),
    .phase_tag_valid  (phase_tag_valid),
    .out_delay        (out_delay),
    .out_period       (out_period),
    .out_period_valid (out_period_valid),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .overflow         (overflow),
    .clr_overflow     (clr_overflow)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct {
    int delay;
    int period;
    bit pv;
  } exp_t;

  exp_t exp_q[$];
  exp_t pipe;
  bit   pipe_v;
  bit   m_has_prev;
  int   m_prev;
  bit   m_ovf;
  int   m_acc;
  int   m_acc_n;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Behavioural reference: one-cycle decode stage feeding a bounded result queue.
  always @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      pipe_v     = 1'b0;
      m_has_prev = 1'b0;
      m_prev     = 0;
      m_ovf      = 1'b0;
      m_acc      = 0;
      m_acc_n    = 0;
    end else begin
      bit   emit;
      bit   dropped;
      exp_t e;
      emit    = 1'b0;
      dropped = 1'b0;
      if (pipe_v) begin
`ifdef PHASE_TAG_DECODER_AVG_EN
        m_acc   = m_acc + pipe.delay;
        m_acc_n = m_acc_n + 1;
        if (m_acc_n == 4) begin
          e       = pipe;
          e.delay = floor_div(m_acc, 4);
          emit    = 1'b1;
          m_acc   = 0;
          m_acc_n = 0;
        end
`else
        e    = pipe;
        emit = 1'b1;
`endif
      end
      if (emit) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      pipe_v = phase_tag_valid;
      if (phase_tag_valid) begin
        int st, ph, sp, tp;
        st = int'(phase_tag[15:10]);
        ph = int'(phase_tag[9:4]);
        sp = int'(phase_tag[3:2]);
        tp = int'(phase_tag[1:0]);
        pipe.delay  = ph * 4 + tp - sp;
        pipe.period = m_has_prev ? (st - m_prev + 64) % 64 : 0;
        pipe.pv     = m_has_prev;
        m_has_prev  = 1'b1;
        m_prev      = st;
      end
    end
  end

  // Monitor: compares the FIFO head with the scoreboard and retires accepted entries.
  always @(negedge clk_0) begin
    if (!rst) begin
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("overflow", int'(overflow), int'(m_ovf));
      if (out_valid && exp_q.size() != 0) begin
        check("delay", int'($signed(out_delay)), exp_q[0].delay);
        check("period", int'(out_period), exp_q[0].period);
        check("period_valid", int'(out_period_valid), int'(exp_q[0].pv));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(int st, int ph, int sp, int tp);
    phase_tag       = {6'(st), 6'(ph), 2'(sp), 2'(tp)};
    phase_tag_valid = 1'b1;
    step();
    phase_tag_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    step();
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", n < 200 ? 1 : 0, 1);
  endtask

  initial begin
    rst             = 1'b1;
    phase_tag       = '0;
    phase_tag_valid = 1'b0;
    out_ready       = 1'b0;
    clr_overflow    = 1'b0;
    idle(3);
    check("rst_delay", int'(out_delay), 0);
    check("rst_period", int'(out_period), 0);
    check("rst_pv", int'(out_period_valid), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    step();

`ifndef PHASE_TAG_DECODER_AVG_EN
    // Single tag: visible two cycles after its strobe
    send(5, 3, 1, 2);
    check("lat_n1_valid", int'(out_valid), 0);
    step();
    check("lat_n2_valid", int'(out_valid), 1);
    check("single_delay", int'(out_delay), 13);
    check("single_pv", int'(out_period_valid), 0);
    drain();

    do_reset();
    out_ready = 1'b1;
    send(5, 1, 0, 0);
    send(15, 1, 0, 0);
    send(60, 1, 0, 0);
    send(4, 1, 0, 0);
    idle(4);

    send(7, 0, 3, 0);
    step();
    check("neg_delay", int'(out_delay), 9'h1FD);
    idle(3);

    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(20 + i, i, 0, 0);
    idle(3);
    check("bp_overflow", int'(overflow), 1);
    check("bp_head", int'(out_delay), 4);
    drain();
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("clr_overflow", int'(overflow), 0);
`else
    do_reset();
    out_ready = 1'b1;
    send(1, 2, 0, 2);
    send(2, 2, 0, 3);
    send(3, 3, 0, 0);
    send(4, 3, 0, 0);
    step();
    check("avg_pos", int'($signed(out_delay)), 11);
    idle(3);
    send(5, 0, 3, 0);
    send(6, 0, 3, 0);
    send(7, 0, 3, 0);
    send(8, 0, 2, 0);
    step();
    check("avg_neg", int'($signed(out_delay)), -3);
    idle(3);
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(i, i, 0, 0);
    idle(3);
    drain();
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
`endif

    // Randomized traffic with backpressure, overflow clears and occasional mid-run resets
    for (int c = 0; c < 3000; c++) begin
      phase_tag_valid = ($urandom_range(0, 99) < 60);
      phase_tag       = 16'($urandom());
      out_ready       = ($urandom_range(0, 99) < 65);
      clr_overflow    = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      else rst = 1'b0;
      step();
    end
    rst             = 1'b0;
    phase_tag_valid = 1'b0;
    clr_overflow    = 1'b0;
    idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_tag_decoder.md
# phase_tag_decoder

Receive-side consumer for the combined phase detector's packed `phase_tag` stream. It unpacks each tag and computes the signed start-to-stop delay in quarter-`clk_0` units, which is the subtraction previously left to software. It also computes the start-edge period from consecutive start counts. Results are buffered in a small FIFO with a valid/ready output so the host-interface logic can apply backpressure without losing tags.

## Interface
Parameters:
- `PHASE_COUNT_SIZE`, 6, width of the phase-count field.
- `CLK_0_COUNT_SIZE`, 6, width of the start-count field.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `AVG_LOG2`, 2, log2 of the averaging window; only used when averaging is compiled in.

Ports:
- `clk_0`  in  1  clock; all logic is in this domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `phase_tag`  in  `CLK_0_COUNT_SIZE+PHASE_COUNT_SIZE+4`  packed tag `{start_count, phase_count, start_phase[1:0], stop_phase[1:0]}`.
- `phase_tag_valid`  in  1  one-cycle strobe marking `phase_tag` valid; no backpressure is possible on this input.
- `out_delay`  out  `PHASE_COUNT_SIZE+3`  signed delay in quarter periods.
- `out_period`  out  `CLK_0_COUNT_SIZE`  start-count difference from the previous tag.
- `out_period_valid`  out  1  `out_period` is meaningful; 0 for the first tag after reset.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head.
- `overflow`  out  1  sticky flag: a result was dropped because the FIFO was full.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Stage 1 (registered on `phase_tag_valid`):
  - Unpack the four fields.
  - Compute `delay = (phase_count << 2) + stop_phase - start_phase`, sign-extended to `PHASE_COUNT_SIZE+3` bits.
  - The valid range is -3 to 4·(2^P-1)+3; the computation never overflows.
- Period is computed as `start_count - prev_start` modulo 2^C, so wrap-around is handled naturally (60 followed by 4 gives 8).
- Tracking FSM states:
  - IDLE: after reset, no previous start is held. The first tag stores `prev_start`, sets `out_period_valid=0` and period=0, and moves to RUN.
  - RUN: every tag updates `prev_start` and emits with `out_period_valid=1`.
- Stage 2 pushes `{delay, period, period_valid}` into the FIFO.
- FIFO is first-word-fall-through:
  - A pop happens when `out_valid && out_ready`.
  - A push while full with no pop in the same cycle drops the new entry and sets `overflow`.
  - A push while full with a simultaneous pop is accepted.
- `overflow` is cleared only by `clr_overflow` or reset. If `clr_overflow` and a drop occur in the same cycle, the set wins.
- Asserting reset mid-operation:
  - empties the FIFO,
  - returns the FSM to IDLE,
  - clears the averaging accumulator.

## Timing
- Reset values: `out_delay=0`, `out_period=0`, `out_period_valid=0`, `out_valid=0`, `overflow=0`.
- Latency: a tag strobed in cycle N is written to the FIFO at the end of cycle N+1. With the FIFO empty, `out_valid=1` in cycle N+2.
- Throughput is one tag per cycle. Back-to-back strobes are all processed.
- Output fields are stable while `out_valid=1 && out_ready=0`.
- `out_valid` deasserts in the cycle after the last entry is popped.

## Configuration
- `PHASE_TAG_DECODER_AVG_EN` defined:
  - Delays are accumulated over 2^`AVG_LOG2` tags in a signed accumulator `PHASE_COUNT_SIZE+3+AVG_LOG2` bits wide.
  - On the last tag of each window, the result is pushed: the arithmetic right shift of the accumulator by `AVG_LOG2` (floor), together with that last tag's period and period_valid.
  - The accumulator and window counter then reset.
  - Latency is measured from the window's final tag, and is unchanged at N+2.
- Not defined: every tag produces one FIFO entry. No accumulator is instantiated and `AVG_LOG2` is ignored.

## Test plan
All scenarios use default parameters.
- Reset: assert `rst` with `out_ready=0`, no tags -> all outputs 0 and `out_valid=0`.
- Single tag: start=5, phase=3, start_phase=1, stop_phase=2, strobed at N (no AVG) -> `out_valid` in N+2 with delay=13, `out_period_valid=0`.
- Period and wrap-around: tags with start 5, 15, 60, 4 -> periods (valid) 10, 45, 8.
- Negative delay: phase=0, start_phase=3, stop_phase=0 -> `out_delay`=-3 (9'h1FD).
- Backpressure: `out_ready=0`, six back-to-back tags with phase 1..6 -> 4 entries held, `overflow=1`. Raising `out_ready` drains delays 4, 8, 12, 16 in order. `clr_overflow` then clears the flag.
- With `PHASE_TAG_DECODER_AVG_EN`: delays 10, 11, 12, 12 -> exactly one entry with delay 11 (45>>2). Delays -3, -3, -3, -2 -> -3 (floor of -11/4).
